// File: rtl/tree_merge_arbiter.sv
// rtl/tree_merge_arbiter.sv - 2:1 round-robin merge of two child ports onto one registered parent port
// Optional idle gating (gate_en port, idle counter) is enabled by defining TREE_GATE_EN.
module tree_merge_arbiter #(
    parameter int WIDTH_packet = 28,
    parameter int WIDTH_addr   = 3,
    parameter int WIDTH_dest   = 3,
    parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
    parameter int IDLE_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             grant_id
`ifdef TREE_GATE_EN
    ,
    output logic             gate_en
`endif
);

    logic prio;
    logic can_load;
    logic winner;
    logic accept;

    // Same-cycle arbitration; only valids and prio steer the readies, never the loser's data.
    // Readies are forced low while rst is held so nothing is taken during reset.
    always_comb begin
        can_load  = !out_valid || out_ready;
        winner    = (in0_valid && in1_valid) ? prio : in1_valid;
        in0_ready = !rst && can_load && in0_valid && !winner;
        in1_ready = !rst && can_load && in1_valid && winner;
        accept    = in0_ready || in1_ready;
    end

    // One-entry output register: reload on accept (also covers drain+reload), clear on pure drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= 1'b0;
            prio      <= 1'b0;
        end else if (accept) begin
            out_data  <= winner ? in1_data : in0_data;
            out_valid <= 1'b1;
            grant_id  <= winner;
            prio      <= ~winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TREE_GATE_EN
    localparam int CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

    logic [CW-1:0] idle_cnt;
    logic          idle;

    // Idle means nothing offered by either child and nothing waiting for the parent.
    always_comb begin
        idle    = !in0_valid && !in1_valid && !out_valid;
        gate_en = (idle_cnt != IDLE_MAX) || in0_valid || in1_valid;
    end

    // Saturating count of consecutive idle cycles; any activity restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (idle) begin
            if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end
`endif

endmodule
